regfile_mp: RTL and testbench

// - Parametrised multi-read-port register file for the Titan datapath; next generation of the 2R/1W file.
// - Adds the following:
//   - NREAD read ports.
//   - A dedicated link (return-address) write port to a fixed register.
//   - Synchronous reset clear.
//   - A sequential soft-clear engine with busy handshake.
//   - Optional same-cycle write-to-read bypass.
// - Sits between instruction decode (addresses) and execute/writeback (data).

---
 rtl/regfile_mp.sv | 110 +++++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with link write port, synchronous reset and a sequential soft-clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp #(
  parameter int REGBITS  = 5,
  parameter int WIDTH    = 32,
  parameter int NREAD    = 2,
  parameter int LINK_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [REGBITS-1:0]       wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     link_en,
  input  logic [WIDTH-1:0]         link_data,
  input  logic [NREAD*REGBITS-1:0] rd_addr,
  output logic [NREAD*WIDTH-1:0]   rd_data,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int                 DEPTH     = 2 ** REGBITS;
  localparam logic [REGBITS-1:0] LINK_ADDR = REGBITS'(LINK_REG);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic [REGBITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               wr_ok;
  logic               link_ok;

  // Soft-clear sequencer: sweeps entries 1..DEPTH-1, one per cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = REGBITS'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + REGBITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // Writes are dropped while clearing; the general port wins a collision on LINK_ADDR.
  assign wr_ok   = wr_en && (wr_addr != '0) && !busy;
  assign link_ok = link_en && (LINK_ADDR != '0) && !busy && !(wr_en && (wr_addr == LINK_ADDR));

  always_ff @(posedge clk) begin
    // NOTE: the array is reset explicitly because reset must clear every register, so it maps to flops, not RAM.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (busy) begin
      mem[cnt_q] <= '0;
    end else begin
      if (link_ok) mem[LINK_ADDR] <= link_data;
      if (wr_ok)   mem[wr_addr]   <= wr_data;
    end
  end

  always_comb begin
    logic [REGBITS-1:0] idx;
    logic [WIDTH-1:0]   val;
    rd_data = '0;
    for (int k = 0; k < NREAD; k++) begin
      idx = rd_addr[k*REGBITS +: REGBITS];
      val = (idx == '0) ? '0 : mem[idx];
`ifdef REGFILE_BYPASS_EN
      // wr_ok/link_ok already exclude busy, r0 and the port collision.
      if (link_ok && (idx == LINK_ADDR)) val = link_data;
      if (wr_ok && (idx == wr_addr))     val = wr_data;
`endif
      rd_data[k*WIDTH +: WIDTH] = val;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected read/busy values, a negedge monitor compares.
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;

  localparam int REGBITS = 5;
  localparam int WIDTH   = 32;
  localparam int NREAD   = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     wr_en;
  logic [REGBITS-1:0]       wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic                     link_en;
  logic [WIDTH-1:0]         link_data;
  logic [NREAD*REGBITS-1:0] rd_addr;
  logic [NREAD*WIDTH-1:0]   rd_data;
  logic                     clr_req;
  logic                     busy;

  regfile_mp #(.REGBITS(REGBITS), .WIDTH(WIDTH), .NREAD(NREAD), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(link_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_busy;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: rd_data and busy are always presented, so every queued entry is checked mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.is_busy) check(e.name, {31'd0, busy}, e.exp);
      else           check(e.name, rd_data[e.port*WIDTH +: WIDTH], e.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [REGBITS-1:0] a0, input logic [REGBITS-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic exp_rd(input int port, input logic [31:0] v, input string name);
    exp_t e;
    e.is_busy = 1'b0; e.port = port; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_busy(input bit v, input string name);
    exp_t e;
    e.is_busy = 1'b1; e.port = 0; e.exp = {31'd0, v}; e.name = name;
    sb.push_back(e);
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic expect_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      exp_rd(0, 32'h0, name);
      exp_rd(1, 32'h0, name);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    link_en = 1'b0; link_data = '0; rd_addr = '0; clr_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    exp_busy(1'b0, "busy_after_reset");
    expect_all_zero("reset_zero");

    // Basic write/read
    set_rd(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    set_rd(5'd5, 5'd0);
    exp_rd(0, 32'hDEADBEEF, "r5_read");
    exp_rd(1, 32'h0, "r0_read");
    tick();

    // Zero register: no store, no bypass
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    set_rd(5'd0, 5'd0);
    exp_rd(0, 32'h0, "r0_no_bypass");
    tick();
    wr_en = 1'b0;
    exp_rd(1, 32'h0, "r0_after_write");
    tick();

    // Port collision on r31: general write wins
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA;
    link_en = 1'b1; link_data = 32'hB;
    set_rd(5'd31, 5'd31);
    exp_rd(0, BYP ? 32'hA : 32'h0, "collision_bypass");
    tick();
    wr_addr = 5'd7; wr_data = 32'h1; link_data = 32'hC;
    set_rd(5'd7, 5'd31);
    exp_rd(0, BYP ? 32'h1 : 32'h0, "dual_bypass_r7");
    exp_rd(1, BYP ? 32'hC : 32'hA, "dual_bypass_r31");
    tick();
    wr_en = 1'b0; link_en = 1'b0;
    exp_rd(0, 32'h1, "dual_r7");
    exp_rd(1, 32'hC, "dual_r31");
    tick();

    // Same-cycle bypass on r9
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    set_rd(5'd9, 5'd5);
    exp_rd(0, BYP ? 32'h55 : 32'h0, "bypass_r9");
    exp_rd(1, 32'hDEADBEEF, "bypass_other_port");
    tick();
    wr_en = 1'b0;
    exp_rd(0, 32'h55, "r9_after_edge");
    tick();

    // Link port alone
    link_en = 1'b1; link_data = 32'hD;
    set_rd(5'd0, 5'd31);
    exp_rd(1, BYP ? 32'hD : 32'hC, "link_bypass");
    tick();
    link_en = 1'b0;
    exp_rd(1, 32'hD, "link_after_edge");
    tick();

    // Soft clear with dropped write and repeated request
    fill_index();
    set_rd(5'd3, 5'd30);
    exp_rd(0, 32'd3, "fill_r3");
    exp_rd(1, 32'd30, "fill_r30");
    clr_req = 1'b1;
    exp_busy(1'b0, "busy_comb_free");
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      wr_en   = (c == 5);
      wr_addr = 5'd3;
      wr_data = 32'hFF;
      clr_req = (c == 10);
      exp_busy(c <= 31, $sformatf("clear_busy_c%0d", c));
      if (c <= 31) begin
        set_rd(5'(c), (c == 5) ? 5'd3 : 5'(c - 1));
        exp_rd(0, 32'(c), $sformatf("clear_pending_c%0d", c));
        exp_rd(1, 32'h0, $sformatf("clear_done_c%0d", c));
      end
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    exp_busy(1'b0, "idle_after_clear");
    expect_all_zero("post_clear_zero");

    // Reset mid-clear
    fill_index();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    exp_busy(1'b1, "busy_at_c10");
    set_rd(5'd20, 5'd31);
    exp_rd(0, 32'd20, "r20_before_reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_busy(1'b0, "busy_after_mid_reset");
    expect_all_zero("mid_reset_zero");
    exp_busy(1'b0, "still_idle");
    tick();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
